// File: rtl/switch_pkg.sv
// Shared types for the switch egress path: port count, port index type and drain FSM states.
package switch_pkg;

  localparam int unsigned NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StLoad,
    StSend
  } drain_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requesting port strictly after last_grant,
// wrapping 0->1->2->3->0, with last_grant itself considered last.
module rr_pick4
  import switch_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            last_grant,
  output port_idx_t            winner,
  output logic                 any
);

  port_idx_t cand;

  always_comb begin
    winner = last_grant;
    any    = 1'b0;
    cand   = last_grant;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      // Offset NUM_PORTS wraps to zero, so last_grant is examined last.
      cand = last_grant + port_idx_t'(i);
      if (!any && req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_drain_arbiter.sv
// Egress scheduler: pops the four switch FIFOs in round-robin bursts of up to MAX_BURST
// bytes and serialises them onto one valid/ready byte stream.
module switch_drain_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_0,
  input  logic              ready_1,
  input  logic              ready_2,
  input  logic              ready_3,
  input  logic [DATA_W-1:0] port0,
  input  logic [DATA_W-1:0] port1,
  input  logic [DATA_W-1:0] port2,
  input  logic [DATA_W-1:0] port3,
  output logic              read_0,
  output logic              read_1,
  output logic              read_2,
  output logic              read_3,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output port_idx_t         grant_id,
  output logic              busy
);

  localparam logic [3:0] BurstMax = 4'(MAX_BURST);

  drain_state_e         state_q;
  logic [3:0]           burst_cnt_q;
  port_idx_t            last_grant_q;

  logic [NUM_PORTS-1:0] ready_vec;
  logic [DATA_W-1:0]    port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] read_vec;
  port_idx_t            pick;
  logic                 pick_any;

  assign ready_vec    = {ready_3, ready_2, ready_1, ready_0};
  assign port_data[0] = port0;
  assign port_data[1] = port1;
  assign port_data[2] = port2;
  assign port_data[3] = port3;

  rr_pick4 u_rr_pick4 (
    .req        (ready_vec),
    .last_grant (last_grant_q),
    .winner     (pick),
    .any        (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      burst_cnt_q  <= '0;
      last_grant_q <= port_idx_t'(NUM_PORTS - 1);
      grant_id     <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            grant_id    <= pick;
            burst_cnt_q <= '0;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StLoad;
        end
        StLoad: begin
          // The popped byte is presented by the FIFO after the ISSUE edge.
          out_data  <= port_data[grant_id];
          out_valid <= 1'b1;
          if (burst_cnt_q < BurstMax) begin
            burst_cnt_q <= burst_cnt_q + 4'd1;
          end
          state_q <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (burst_cnt_q < BurstMax && ready_vec[grant_id]) begin
              state_q <= StIssue;
            end else begin
              last_grant_q <= grant_id;
              state_q      <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Pop strobes depend only on registered state, never on same-cycle inputs.
  always_comb begin
    read_vec = '0;
    if (state_q == StIssue) begin
      read_vec[grant_id] = 1'b1;
    end
  end

  assign read_0 = read_vec[0];
  assign read_1 = read_vec[1];
  assign read_2 = read_vec[2];
  assign read_3 = read_vec[3];
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_switch_drain_arbiter.sv
// Bench for switch_drain_arbiter: two instances (MAX_BURST 4 and 1) fed by FIFO models,
// checked against a transaction-level round-robin drain model under random backpressure.
module tb_switch_drain_arbiter;

  localparam int NumDut = 2;
  localparam int Depth  = 32;
  localparam int ExpMax = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset    = 1'b1;
  logic       fifo_clr = 1'b1;

  logic [7:0]  mem     [NumDut][4][Depth];
  int unsigned wr_cnt  [NumDut][4];
  int unsigned rd_ptr  [NumDut][4];
  logic [7:0]  head    [NumDut][4];
  logic        rdy     [NumDut][4];
  logic        rd      [NumDut][4];
  logic [7:0]  odata   [NumDut];
  logic        ovalid  [NumDut];
  logic        oready  [NumDut];
  logic [1:0]  gid     [NumDut];
  logic        bsy     [NumDut];

  logic [7:0]  exp_data  [NumDut][ExpMax];
  logic [1:0]  exp_grant [NumDut][ExpMax];
  int          exp_n     [NumDut];
  int          obs_n     [NumDut];

  bit          hold      [NumDut];
  logic [7:0]  hold_data [NumDut];
  int          hold_cnt  [NumDut];
  bit          prev_busy [NumDut];
  logic [1:0]  prev_gid  [NumDut];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    switch_drain_arbiter #(
      .MAX_BURST ((g == 0) ? 4 : 1),
      .DATA_W    (8)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .ready_0   (rdy[g][0]),
      .ready_1   (rdy[g][1]),
      .ready_2   (rdy[g][2]),
      .ready_3   (rdy[g][3]),
      .port0     (head[g][0]),
      .port1     (head[g][1]),
      .port2     (head[g][2]),
      .port3     (head[g][3]),
      .read_0    (rd[g][0]),
      .read_1    (rd[g][1]),
      .read_2    (rd[g][2]),
      .read_3    (rd[g][3]),
      .out_data  (odata[g]),
      .out_valid (ovalid[g]),
      .out_ready (oready[g]),
      .grant_id  (gid[g]),
      .busy      (bsy[g])
    );
  end

  // FIFO model: a pop at an edge presents the next stored byte after that edge.
  always_comb begin
    for (int d = 0; d < NumDut; d++) begin
      for (int p = 0; p < 4; p++) begin
        rdy[d][p] = (rd_ptr[d][p] != wr_cnt[d][p]);
      end
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < NumDut; d++) begin
      for (int p = 0; p < 4; p++) begin
        if (fifo_clr) begin
          rd_ptr[d][p] <= 0;
        end else if (rd[d][p] && rdy[d][p]) begin
          head[d][p]   <= mem[d][p][rd_ptr[d][p]];
          rd_ptr[d][p] <= rd_ptr[d][p] + 1;
        end
      end
    end
  end

  function automatic int mb_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic [3:0] rd_vec(input int d);
    return {rd[d][3], rd[d][2], rd[d][1], rd[d][0]};
  endfunction

  function automatic logic [3:0] rdy_vec(input int d);
    return {rdy[d][3], rdy[d][2], rdy[d][1], rdy[d][0]};
  endfunction

  function automatic string tg(input string s, input int d);
    return $sformatf("%s[dut%0d]", s, d);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_both(input int p, input logic [7:0] b);
    for (int d = 0; d < NumDut; d++) begin
      mem[d][p][wr_cnt[d][p]] = b;
      wr_cnt[d][p]++;
    end
  endtask

  // Drain order from the arbitration rules alone: next non-empty port after the last one,
  // taking up to MAX_BURST bytes per grant; starts as if port 3 had just been served.
  task automatic build_expect();
    for (int d = 0; d < NumDut; d++) begin
      int pos [4];
      int last;
      bit found;
      int p;
      for (int q = 0; q < 4; q++) pos[q] = 0;
      last = 3;
      exp_n[d] = 0;
      forever begin
        found = 1'b0;
        p = 0;
        for (int i = 1; i <= 4; i++) begin
          if (!found && pos[(last + i) % 4] < int'(wr_cnt[d][(last + i) % 4])) begin
            p = (last + i) % 4;
            found = 1'b1;
          end
        end
        if (!found) break;
        for (int k = 0; k < mb_of(d) && pos[p] < int'(wr_cnt[d][p]); k++) begin
          exp_data[d][exp_n[d]]  = mem[d][p][pos[p]];
          exp_grant[d][exp_n[d]] = 2'(p);
          exp_n[d]++;
          pos[p]++;
        end
        last = p;
      end
    end
  endtask

  task automatic begin_scn();
    @(negedge clk);
    reset    = 1'b1;
    fifo_clr = 1'b1;
    for (int d = 0; d < NumDut; d++) begin
      oready[d]    = 1'b0;
      obs_n[d]     = 0;
      hold[d]      = 1'b0;
      hold_cnt[d]  = 0;
      prev_busy[d] = 1'b0;
      prev_gid[d]  = '0;
      for (int p = 0; p < 4; p++) wr_cnt[d][p] = 0;
    end
    @(negedge clk);
    fifo_clr = 1'b0;
    for (int d = 0; d < NumDut; d++) begin
      check_eq(tg("rst_out_valid", d), 32'(ovalid[d]), 0);
      check_eq(tg("rst_out_data", d), 32'(odata[d]), 0);
      check_eq(tg("rst_read", d), 32'(rd_vec(d)), 0);
      check_eq(tg("rst_grant_id", d), 32'(gid[d]), 0);
      check_eq(tg("rst_busy", d), 32'(bsy[d]), 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      logic [3:0] rv;
      rv = rd_vec(d);
      check_eq(tg("read_onehot", d), 32'($countones(rv) <= 1), 1);
      if (rv != 4'd0) begin
        check_eq(tg("read_when_busy", d), 32'(bsy[d]), 1);
        check_eq(tg("read_while_valid", d), 32'(ovalid[d]), 0);
        check_eq(tg("read_ready_port", d), 32'(|(rv & rdy_vec(d))), 1);
      end
      if (hold[d]) begin
        check_eq(tg("bp_valid_hold", d), 32'(ovalid[d]), 1);
        check_eq(tg("bp_data_hold", d), 32'(odata[d]), 32'(hold_data[d]));
      end
      if (prev_busy[d] && bsy[d]) begin
        check_eq(tg("grant_stable", d), 32'(gid[d]), 32'(prev_gid[d]));
      end
      prev_busy[d] = bsy[d];
      prev_gid[d]  = gid[d];

      if (hold_cnt[d] > 0) begin
        oready[d] = 1'b0;
        hold_cnt[d]--;
      end else if ($urandom_range(7) == 0) begin
        oready[d]   = 1'b0;
        hold_cnt[d] = 4;
      end else begin
        oready[d] = ($urandom_range(3) != 0);
      end
      hold[d]      = ovalid[d] && !oready[d];
      hold_data[d] = odata[d];
      if (ovalid[d] && oready[d]) begin
        check_eq(tg("xfer_in_range", d), 32'(obs_n[d] < exp_n[d]), 1);
        if (obs_n[d] < exp_n[d]) begin
          check_eq(tg("xfer_data", d), 32'(odata[d]), 32'(exp_data[d][obs_n[d]]));
          check_eq(tg("xfer_grant", d), 32'(gid[d]), 32'(exp_grant[d][obs_n[d]]));
        end
        obs_n[d]++;
      end
    end
  endtask

  task automatic run_to_drain();
    bit done;
    build_expect();
    @(negedge clk);
    reset = 1'b0;
    done  = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      step();
      done = 1'b1;
      for (int d = 0; d < NumDut; d++) begin
        if (obs_n[d] < exp_n[d] || bsy[d]) done = 1'b0;
      end
    end
    for (int d = 0; d < NumDut; d++) begin
      check_eq(tg("drain_count", d), 32'(obs_n[d]), 32'(exp_n[d]));
      check_eq(tg("fifos_empty", d), 32'(rdy_vec(d)), 0);
    end
  endtask

  initial begin
    for (int d = 0; d < NumDut; d++) begin
      oready[d] = 1'b0;
      for (int p = 0; p < 4; p++) wr_cnt[d][p] = 0;
    end

    // Single byte on port 2: exact pop/valid timing.
    begin_scn();
    push_both(2, 8'hA5);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < NumDut; d++) oready[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      check_eq(tg("sb_issue_read", d), 32'(rd_vec(d)), 32'h4);
      check_eq(tg("sb_issue_grant", d), 32'(gid[d]), 2);
      check_eq(tg("sb_issue_busy", d), 32'(bsy[d]), 1);
    end
    @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      check_eq(tg("sb_load_read", d), 32'(rd_vec(d)), 0);
      check_eq(tg("sb_load_valid", d), 32'(ovalid[d]), 0);
    end
    @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      check_eq(tg("sb_send_valid", d), 32'(ovalid[d]), 1);
      check_eq(tg("sb_send_data", d), 32'(odata[d]), 32'hA5);
      check_eq(tg("sb_send_read", d), 32'(rd_vec(d)), 0);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < NumDut; d++) begin
        check_eq(tg("sb_idle_valid", d), 32'(ovalid[d]), 0);
        check_eq(tg("sb_idle_busy", d), 32'(bsy[d]), 0);
        check_eq(tg("sb_idle_read", d), 32'(rd_vec(d)), 0);
      end
    end

    // Reset while a byte waits in SEND; afterwards port 0 must win over port 1.
    begin_scn();
    push_both(1, 8'h31);
    push_both(1, 8'h32);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10 && !ovalid[0]; c++) @(negedge clk);
    check_eq("rs_reached_send", 32'(ovalid[0]), 1);
    push_both(0, 8'h40);
    reset = 1'b1;
    #1;
    for (int d = 0; d < NumDut; d++) begin
      check_eq(tg("rs_async_valid", d), 32'(ovalid[d]), 0);
      check_eq(tg("rs_async_data", d), 32'(odata[d]), 0);
      check_eq(tg("rs_async_busy", d), 32'(bsy[d]), 0);
      check_eq(tg("rs_async_grant", d), 32'(gid[d]), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NumDut; d++) begin
      check_eq(tg("rs_first_grant", d), 32'(gid[d]), 0);
      check_eq(tg("rs_first_read", d), 32'(rd_vec(d)), 32'h1);
    end

    // Burst cap: six bytes on port 0.
    begin_scn();
    for (int i = 0; i < 6; i++) push_both(0, 8'(8'h10 + i));
    run_to_drain();

    // Round robin: two bytes on every port.
    begin_scn();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 4; p++) push_both(p, 8'((p << 4) | (8'hA + i)));
    end
    run_to_drain();

    // Ready drop: port 1 empties after one pop, then port 2 is next.
    begin_scn();
    push_both(1, 8'h51);
    push_both(2, 8'h62);
    push_both(2, 8'h63);
    push_both(3, 8'h74);
    run_to_drain();

    // Random FIFO contents.
    for (int s = 0; s < 25; s++) begin
      begin_scn();
      for (int p = 0; p < 4; p++) begin
        int n;
        n = $urandom_range(7);
        for (int i = 0; i < n; i++) push_both(p, 8'($urandom));
      end
      run_to_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
